// File: rtl/filter_pkg.sv
// Shared constants, types and the output saturation helper for the tap FIR.
package filter_pkg;

  localparam int NTAPS     = 8;
  localparam int DW        = 16;
  localparam int CW        = 16;
  localparam int FRAC_BITS = 14;
  localparam int ACC_W     = 36;
  localparam int PROD_W    = DW + CW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [CW-1:0] coef_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -36'sd32768;

  // Drop the Q2.14 fraction (floor, via arithmetic shift) and clip to 16 bits.
  function automatic sample_t sat16(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_BITS;
    if (sh > SAT_MAX)      return 16'sh7FFF;
    else if (sh < SAT_MIN) return 16'sh8000;
    else                   return sh[DW-1:0];
  endfunction

endpackage

// File: rtl/tap_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
module tap_mac
  import filter_pkg::*;
(
  input  logic                    clk,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  coef_t                   i_a,
  input  sample_t                 i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign o_acc      = r_acc;

  // Accumulator: clear wins over enable.
  always_ff @(posedge clk) begin
    if (i_clr)     r_acc <= '0;
    else if (i_en) r_acc <= r_acc + w_prod_ext;
  end

endmodule

// File: rtl/tap_fir_filter.sv
// 8-tap time-multiplexed FIR: one MAC per clock, one sample every 10 clocks.
//
//   state | meaning
//   IDLE  | ready high; waits for sampleValid, then shifts sample in and snapshots taps
//   MAC   | eight accumulate cycles, tap index 0..7
//   DONE  | scale, saturate and publish sampleOut with a one-cycle outValid
module tap_fir_filter
  import filter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NTAPS*CW-1:0]  allTaps,
  input  logic [DW-1:0]        sampleIn,
  input  logic                 sampleValid,
  output logic                 ready,
  output logic [DW-1:0]        sampleOut,
  output logic                 outValid
);

  state_t                  r_state;
  sample_t                 r_x   [NTAPS];
  coef_t                   r_tap [NTAPS];
  logic [2:0]              r_idx;
  sample_t                 r_sample_out;
  logic                    r_out_valid;

  logic                    w_accept;
  logic                    w_clr;
  logic                    w_en;
  logic signed [ACC_W-1:0] w_acc;

  assign ready     = (r_state == IDLE);
  assign w_accept  = sampleValid && (r_state == IDLE);
  // Reset also clears the accumulator so an aborted sum never leaks out.
  assign w_clr     = !reset || w_accept;
  assign w_en      = (r_state == MAC);
  assign sampleOut = r_sample_out;
  assign outValid  = r_out_valid;

  tap_mac u_mac (
    .clk   (clk),
    .i_clr (w_clr),
    .i_en  (w_en),
    .i_a   (r_tap[r_idx]),
    .i_b   (r_x[r_idx]),
    .o_acc (w_acc)
  );

  // Sequencer, delay line, tap snapshot and output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_sample_out <= '0;
      r_out_valid  <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        r_x[k]   <= '0;
        r_tap[k] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sampleValid) begin
            r_x[0] <= sampleIn;
            for (int k = 1; k < NTAPS; k++) r_x[k] <= r_x[k-1];
            // tap0 lives in the MSBs of the bus
            for (int k = 0; k < NTAPS; k++)
              r_tap[k] <= allTaps[NTAPS*CW-1-CW*k -: CW];
            r_idx   <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'(NTAPS-1)) r_state <= DONE;
        end
        DONE: begin
          r_sample_out <= sat16(w_acc);
          r_out_valid  <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_fir_filter.sv
// Directed bench for tap_fir_filter: impulse, saturation, busy drop,
// mid-flight tap change and mid-computation reset.
module tb_tap_fir_filter;

  logic         clk;
  logic         reset;
  logic [127:0] allTaps;
  logic [15:0]  sampleIn;
  logic         sampleValid;
  logic         ready;
  logic [15:0]  sampleOut;
  logic         outValid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  localparam logic [127:0] TAPS_IMP = 128'h4000_2000_1000_0800_0000_0000_0000_0000;
  localparam logic [127:0] TAPS_ONE = {8{16'h4000}};

  logic [15:0] imp_exp [8] = '{16'h0100, 16'h0080, 16'h0040, 16'h0020,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] neg_exp [8] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFC,
                               16'h8000, 16'h8000, 16'h8000, 16'h8000};

  tap_fir_filter dut (
    .clk         (clk),
    .reset       (reset),
    .allTaps     (allTaps),
    .sampleIn    (sampleIn),
    .sampleValid (sampleValid),
    .ready       (ready),
    .sampleOut   (sampleOut),
    .outValid    (outValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset       = 1'b0;
    sampleValid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Waits for ready, presents the sample for one edge; returns at the negedge after E0.
  task automatic accept_sample(input logic [15:0] v);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, ready}, 32'd1);
    sampleIn    = v;
    sampleValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sampleValid = 1'b0;
    t0 = cyc;
  endtask

  // Waits for the outValid pulse and checks both value and latency.
  task automatic collect(input string tag, input logic [15:0] exp);
    int n;
    n = 0;
    while (!outValid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, outValid}, 32'd1);
    chk({tag, "_lat"}, cyc - t0, 32'd9);
    chk(tag, {16'd0, sampleOut}, {16'd0, exp});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, outValid}, 32'd0);
  endtask

  initial begin
    int hits;
    reset       = 1'b0;
    allTaps     = '0;
    sampleIn    = '0;
    sampleValid = 1'b0;

    // reset state
    apply_reset();
    chk("rst_out",   {16'd0, sampleOut}, 32'd0);
    chk("rst_valid", {31'd0, outValid},  32'd0);
    chk("rst_ready", {31'd0, ready},     32'd1);

    // impulse response
    allTaps = TAPS_IMP;
    for (int i = 0; i < 8; i++) begin
      accept_sample(i == 0 ? 16'h0100 : 16'h0000);
      collect($sformatf("imp%0d", i), imp_exp[i]);
    end

    // positive saturation then ramp through to negative clip
    apply_reset();
    allTaps = TAPS_ONE;
    for (int i = 0; i < 8; i++) begin
      accept_sample(16'h7FFF);
      collect($sformatf("pos%0d", i), 16'h7FFF);
    end
    for (int i = 0; i < 8; i++) begin
      accept_sample(16'h8000);
      collect($sformatf("neg%0d", i), neg_exp[i]);
    end

    // sample offered while busy must be dropped
    apply_reset();
    allTaps = TAPS_ONE;
    accept_sample(16'h0100);
    @(negedge clk);
    chk("busy_ready", {31'd0, ready}, 32'd0);
    sampleIn    = 16'h1234;
    sampleValid = 1'b1;
    repeat (3) @(negedge clk);
    sampleValid = 1'b0;
    collect("busy_a", 16'h0100);
    accept_sample(16'h0200);
    collect("busy_b", 16'h0300);

    // taps changed during MAC do not affect the in-flight sample
    apply_reset();
    allTaps = TAPS_IMP;
    accept_sample(16'h0100);
    repeat (3) @(negedge clk);
    allTaps = '0;
    collect("tapchg_a", 16'h0100);
    accept_sample(16'h0100);
    collect("tapchg_b", 16'h0000);

    // reset mid-MAC aborts and clears the delay line
    apply_reset();
    allTaps = TAPS_IMP;
    accept_sample(16'h7000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      if (outValid) hits++;
      @(negedge clk);
    end
    chk("abort_pulses", hits, 32'd0);
    chk("abort_out",   {16'd0, sampleOut}, 32'd0);
    chk("abort_ready", {31'd0, ready},     32'd1);
    accept_sample(16'h0100);
    collect("abort_a", 16'h0100);
    accept_sample(16'h0000);
    collect("abort_b", 16'h0080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
